bitpack_fifo_scheduler: RTL and testbench

- Shares one bit-packing FIFO (512-bit buffer, variable-size writes, fixed 128-bit MSB-first reads) between N variable-length producers, e.g. compressed-weight or metadata streams.
- Round-robin arbitrates producer chunks into the FIFO and keeps a shadow occupancy count. It never issues write and read together, because a same-cycle read would drop the write.
- Schedules 128-bit reads into a one-entry valid/ready output stage.
- Handles end-of-stream flush by zero-padding the tail to a whole word.

---
 rtl/bitpack_pkg.sv | 19 +
 rtl/bitpack_fifo_scheduler_arb.sv | 51 +++++
 rtl/bitpack_fifo_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_bitpack_fifo_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitpack_pkg.sv
// Shared constants, FSM state type and helpers for the bit-packing FIFO scheduler.
package bitpack_pkg;

    localparam int unsigned FIFO_BITS = 512;
    localparam int unsigned WORD_BITS = 128;
    localparam int unsigned IN_BITS   = 256;
    localparam int unsigned SIZE_W    = 9;
    localparam int unsigned OCC_W     = 10;

    typedef enum logic [1:0] {ARB, RD_WAIT, PAD, FLUSHED} state_t;

    // Zero bits needed to round a partial tail up to one whole read word.
    function automatic logic [SIZE_W-1:0] pad_bits(input logic [OCC_W-1:0] fill);
        logic [OCC_W-1:0] diff;
        diff = OCC_W'(WORD_BITS) - fill;
        return diff[SIZE_W-1:0];
    endfunction

endpackage

// File: rtl/bitpack_fifo_scheduler_arb.sv
// Round-robin arbiter with per-request eligibility; pointer moves past the winner on grant.
module rr_arbiter_masked #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] eligible,
    input  logic             advance,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    int unsigned      scan;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        scan      = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan = (int'(ptr_q) + k) % N_REQ;
            if (!gnt_valid && req[scan] && eligible[scan]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(scan);
            end
        end
        gnt = '0;
        if (gnt_valid) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && gnt_valid) begin
            ptr_d = (int'(gnt_idx) == int'(N_REQ) - 1) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bitpack_fifo_scheduler.sv
// Schedules N producers' variable-size chunks into a shared bit-packing FIFO and drains
// it as fixed words into a one-entry valid/ready output stage, with zero-padded flush.
module bitpack_fifo_scheduler
    import bitpack_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*IN_BITS-1:0]  req_data,
    input  logic [N_REQ*SIZE_W-1:0]   req_size,
    output logic [N_REQ-1:0]          req_ack,
    output logic [IN_BITS-1:0]        fifo_wdata,
    output logic [SIZE_W-1:0]         fifo_wsize,
    output logic                      fifo_we,
    output logic                      fifo_re,
    input  logic [WORD_BITS-1:0]      fifo_rdata,
    output logic                      out_valid,
    output logic [WORD_BITS-1:0]      out_data,
    input  logic                      out_ready,
    input  logic                      flush,
    output logic                      flush_done,
    output logic [OCC_W-1:0]          occ
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t                 state_q, state_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic [N_REQ-1:0]       ack_q, ack_d;
    logic                   we_q, we_d, re_q, re_d;
    logic [IN_BITS-1:0]     wdata_q, wdata_d;
    logic [SIZE_W-1:0]      wsize_q, wsize_d;
    logic                   cap_q, cap_d;
    logic                   out_valid_q, out_valid_d;
    logic [WORD_BITS-1:0]   out_data_q, out_data_d;
    logic                   done_q, done_d;

    logic [N_REQ-1:0]       eligible;
    logic [N_REQ-1:0]       gnt;
    logic                   gnt_valid;
    logic [IDX_W-1:0]       gnt_idx;
    logic                   grant_en;
    logic [SIZE_W-1:0]      sz_i, gnt_size;
    logic                   slot_free, rd_ok;

    // A requester acked this cycle still shows its old chunk, so it is masked out.
    always_comb begin
        eligible = '0;
        sz_i     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            sz_i        = req_size[i*SIZE_W +: SIZE_W];
            eligible[i] = !ack_q[i] && (OCC_W'(sz_i) + occ_q <= OCC_W'(FIFO_BITS - 1));
        end
    end

    rr_arbiter_masked #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .eligible  (eligible),
        .advance   (grant_en),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign gnt_size  = req_size[int'(gnt_idx)*SIZE_W +: SIZE_W];
    // A word still being captured occupies the slot even though out_valid is low.
    assign slot_free = !cap_q && (!out_valid_q || out_ready);
    assign rd_ok     = occ_q >= OCC_W'(WORD_BITS);

    always_comb begin
        state_d  = state_q;
        occ_d    = occ_q;
        ack_d    = '0;
        we_d     = 1'b0;
        re_d     = 1'b0;
        wdata_d  = '0;
        wsize_d  = '0;
        cap_d    = 1'b0;
        done_d   = 1'b0;
        grant_en = 1'b0;
        case (state_q)
            ARB: begin
                if (rd_ok && slot_free) begin
                    re_d    = 1'b1;
                    occ_d   = occ_q - OCC_W'(WORD_BITS);
                    state_d = RD_WAIT;
                end else if (!flush) begin
                    grant_en = 1'b1;
                    if (gnt_valid) begin
                        ack_d = gnt;
                        if (gnt_size != '0) begin
                            we_d    = 1'b1;
                            wdata_d = req_data[int'(gnt_idx)*IN_BITS +: IN_BITS];
                            wsize_d = gnt_size;
                            occ_d   = occ_q + OCC_W'(gnt_size);
                        end
                    end
                end else if (occ_q != '0 && !rd_ok) begin
                    state_d = PAD;
                end else if (occ_q == '0 && !out_valid_q && !cap_q) begin
                    done_d  = 1'b1;
                    state_d = FLUSHED;
                end
            end
            RD_WAIT: begin
                cap_d   = 1'b1;
                state_d = ARB;
            end
            PAD: begin
                we_d    = 1'b1;
                wsize_d = pad_bits(occ_q);
                occ_d   = OCC_W'(WORD_BITS);
                state_d = ARB;
            end
            FLUSHED: begin
                if (!flush) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (cap_q) begin
            out_valid_d = 1'b1;
            out_data_d  = fifo_rdata;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB;
            occ_q       <= '0;
            ack_q       <= '0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            wdata_q     <= '0;
            wsize_q     <= '0;
            cap_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            occ_q       <= occ_d;
            ack_q       <= ack_d;
            we_q        <= we_d;
            re_q        <= re_d;
            wdata_q     <= wdata_d;
            wsize_q     <= wsize_d;
            cap_q       <= cap_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    assign req_ack    = ack_q;
    assign fifo_we    = we_q;
    assign fifo_re    = re_q;
    assign fifo_wdata = wdata_q;
    assign fifo_wsize = wsize_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign flush_done = done_q;
    assign occ        = occ_q;

    // The FIFO drops a write issued in the same cycle as a read.
    we_re_excl: assert property (@(posedge clk) disable iff (rst) !(fifo_we && fifo_re));

endmodule

// File: tb/tb_bitpack_fifo_scheduler.sv
// Scoreboard bench: behavioural bit-packing FIFO, queued producers, word-level compare.
module tb_bitpack_fifo_scheduler;
    import bitpack_pkg::*;

    localparam int N = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N-1:0]           req_valid;
    logic [N*IN_BITS-1:0]   req_data;
    logic [N*SIZE_W-1:0]    req_size;
    logic [N-1:0]           req_ack;
    logic [IN_BITS-1:0]     fifo_wdata;
    logic [SIZE_W-1:0]      fifo_wsize;
    logic                   fifo_we, fifo_re;
    logic [WORD_BITS-1:0]   fifo_rdata;
    logic                   out_valid, out_ready, flush, flush_done;
    logic [WORD_BITS-1:0]   out_data;
    logic [OCC_W-1:0]       occ;

    bitpack_fifo_scheduler #(.N_REQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_size   (req_size),
        .req_ack    (req_ack),
        .fifo_wdata (fifo_wdata),
        .fifo_wsize (fifo_wsize),
        .fifo_we    (fifo_we),
        .fifo_re    (fifo_re),
        .fifo_rdata (fifo_rdata),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .flush      (flush),
        .flush_done (flush_done),
        .occ        (occ)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SIZE_W-1:0]  size;
        logic [IN_BITS-1:0] data;
    } chunk_t;

    chunk_t pq[N][$];
    bit     exp_q[$];
    bit     fq[$];
    int     ack_log[$];
    int     pad_log[$];
    int     n_checks = 0, n_pass = 0;
    int     both_cnt = 0, re_cnt = 0, fd_cnt = 0, words = 0, extra_acks = 0, sb_bits = 0;
    int     prev_occ = 0, ack0_prev_occ = -1;

    task automatic check(input string tag, input logic [WORD_BITS-1:0] got,
                         input logic [WORD_BITS-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Behavioural packing FIFO: MSB-first append, registered 128-bit pop.
    function automatic logic [WORD_BITS-1:0] pop_word();
        logic [WORD_BITS-1:0] w;
        w = '0;
        for (int b = 0; b < int'(WORD_BITS); b++)
            w[WORD_BITS-1-b] = (fq.size() > 0) ? fq.pop_front() : 1'b0;
        return w;
    endfunction

    function automatic void push_write(input logic [IN_BITS-1:0] d, input int n);
        for (int b = 0; b < n; b++) fq.push_back(d[IN_BITS-1-b]);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            fifo_rdata <= '0;
        end else begin
            if (fifo_we) push_write(fifo_wdata, int'(fifo_wsize));
            if (fifo_re) fifo_rdata <= pop_word();
        end
    end

    function automatic void consume(input int i);
        chunk_t c;
        if (pq[i].size() == 0) begin
            extra_acks++;
            return;
        end
        c = pq[i].pop_front();
        ack_log.push_back(i);
        for (int b = 0; b < int'(c.size); b++) exp_q.push_back(c.data[IN_BITS-1-b]);
        sb_bits += int'(c.size);
    endfunction

    // Producer driver: retire acked chunks and present the next head.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_size  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst)
                for (int i = 0; i < N; i++) if (req_ack[i]) consume(i);
            for (int i = 0; i < N; i++) begin
                req_valid[i] = pq[i].size() > 0;
                if (pq[i].size() > 0) begin
                    req_data[i*IN_BITS +: IN_BITS] = pq[i][0].data;
                    req_size[i*SIZE_W +: SIZE_W]   = pq[i][0].size;
                end
            end
        end
    end

    task automatic compare_word();
        logic [WORD_BITS-1:0] e;
        if (exp_q.size() < int'(WORD_BITS)) begin
            check("sb_underflow", WORD_BITS'(exp_q.size()), WORD_BITS'(WORD_BITS));
        end else begin
            e = '0;
            for (int b = 0; b < int'(WORD_BITS); b++) e[WORD_BITS-1-b] = exp_q.pop_front();
            check("out_word", out_data, e);
        end
        words++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (fifo_we && fifo_re) both_cnt++;
                if (fifo_re) re_cnt++;
                if (flush_done) fd_cnt++;
                if (fifo_we && flush) pad_log.push_back(int'(fifo_wsize));
                if (req_ack[0]) ack0_prev_occ = prev_occ;
                prev_occ = int'(occ);
                if (out_valid && out_ready) compare_word();
            end
        end
    end

    task automatic push_chunk(input int i, input int size);
        chunk_t c;
        c.size = SIZE_W'(size);
        for (int k = 0; k < 8; k++) c.data[k*32 +: 32] = $urandom;
        pq[i].push_back(c);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < N; i++) pq[i].delete();
        exp_q.delete();
        ack_log.delete();
        sb_bits = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_prod_empty(input string tag, input int budget);
        int t = 0;
        while ((pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size()) > 0 && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) check(tag, 0, 1);
    endtask

    task automatic do_flush(input string tag, input int exp_pad);
        int t = 0;
        int fd0 = fd_cnt;
        int np = pad_log.size();
        for (int b = 0; b < exp_pad; b++) exp_q.push_back(1'b0);
        flush = 1'b1;
        while (fd_cnt == fd0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check({tag, "_timeout"}, 0, 1);
        repeat (4) @(negedge clk);
        check({tag, "_pad_count"}, WORD_BITS'(pad_log.size() - np), 1);
        if (pad_log.size() > np) check({tag, "_pad_size"}, WORD_BITS'(pad_log[np]), WORD_BITS'(exp_pad));
        check({tag, "_done_pulses"}, WORD_BITS'(fd_cnt - fd0), 1);
        check({tag, "_occ"}, WORD_BITS'(occ), 0);
        flush = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int w0, r0, t;
        logic [WORD_BITS-1:0] snap;
        out_ready = 1'b1;
        flush     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_occ", WORD_BITS'(occ), 0);
        check("rst_out_valid", WORD_BITS'(out_valid), 0);
        check("rst_out_data", out_data, 0);
        check("rst_we_re", WORD_BITS'({fifo_we, fifo_re}), 0);
        check("rst_ack", WORD_BITS'(req_ack), 0);
        check("rst_flush_done", WORD_BITS'(flush_done), 0);
        check("rst_wdata_wsize", WORD_BITS'(fifo_wdata) | WORD_BITS'(fifo_wsize), 0);
        rst = 1'b0;

        // Two 100-bit chunks, one word out, then flush the 72-bit tail.
        w0 = words; r0 = re_cnt;
        push_chunk(0, 100);
        push_chunk(0, 100);
        wait_prod_empty("t1_wait", 100);
        repeat (8) @(negedge clk);
        check("t1_ack_count", WORD_BITS'(ack_log.size()), 2);
        check("t1_occ", WORD_BITS'(occ), 72);
        check("t1_reads", WORD_BITS'(re_cnt - r0), 1);
        check("t1_words", WORD_BITS'(words - w0), 1);
        do_flush("t1_flush", (128 - sb_bits % 128) % 128);
        check("t1_words_total", WORD_BITS'(words - w0), 2);

        // Four producers, size 64, two chunks each: strict rotation.
        apply_reset();
        w0 = words; both_cnt = 0;
        for (int i = 0; i < N; i++) begin
            push_chunk(i, 64);
            push_chunk(i, 64);
        end
        wait_prod_empty("t2_wait", 200);
        repeat (10) @(negedge clk);
        check("t2_ack_count", WORD_BITS'(ack_log.size()), 8);
        for (int k = 0; k < 8; k++)
            if (k < ack_log.size()) check($sformatf("t2_ack_order%0d", k),
                                          WORD_BITS'(ack_log[k]), WORD_BITS'(k % N));
        check("t2_we_re_excl", WORD_BITS'(both_cnt), 0);
        check("t2_occ", WORD_BITS'(occ), 0);
        check("t2_words", WORD_BITS'(words - w0), 4);

        // Back-pressure to occ=400, then an oversize head that must wait for reads.
        apply_reset();
        w0 = words;
        @(posedge clk); #1 out_ready = 1'b0;
        push_chunk(3, 256);
        push_chunk(3, 256);
        push_chunk(3, 16);
        wait_prod_empty("t3_wait", 100);
        repeat (6) @(negedge clk);
        check("t3_occ400", WORD_BITS'(occ), 400);
        check("t3_out_valid", WORD_BITS'(out_valid), 1);
        snap = out_data;
        r0 = re_cnt;
        ack0_prev_occ = -1;
        push_chunk(0, 200);
        push_chunk(1, 50);
        repeat (12) @(negedge clk);
        check("t3_p1_acked", WORD_BITS'(pq[1].size()), 0);
        check("t3_p0_held", WORD_BITS'(pq[0].size()), 1);
        check("t3_occ450", WORD_BITS'(occ), 450);
        check("t3_no_read", WORD_BITS'(re_cnt - r0), 0);
        check("t3_data_stable", out_data, snap);
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t4_read_after_free", WORD_BITS'(fifo_re), 1);
        wait_prod_empty("t3_p0_wait", 100);
        check("t3_p0_admissible", WORD_BITS'(ack0_prev_occ >= 0 && ack0_prev_occ <= 311), 1);
        repeat (20) @(negedge clk);
        check("t3_occ_tail", WORD_BITS'(occ), 10);
        do_flush("t3_flush", (128 - sb_bits % 128) % 128);
        check("t3_words", WORD_BITS'(words - w0), 7);

        // Asynchronous reset while a read is in flight.
        apply_reset();
        push_chunk(0, 128);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!fifo_re && t < 40);
        if (t >= 40) check("t6_read_timeout", 0, 1);
        #1 rst = 1'b1;
        #1;
        check("t6_out_valid", WORD_BITS'(out_valid), 0);
        check("t6_occ", WORD_BITS'(occ), 0);
        check("t6_re", WORD_BITS'(fifo_re), 0);
        for (int i = 0; i < N; i++) pq[i].delete();
        exp_q.delete();
        sb_bits = 0;
        @(negedge clk);
        rst = 1'b0;
        w0 = words;
        push_chunk(0, 128);
        wait_prod_empty("t6_wait", 50);
        repeat (8) @(negedge clk);
        check("t6_words_after", WORD_BITS'(words - w0), 1);
        check("t6_occ_after", WORD_BITS'(occ), 0);
        check("spurious_ack", WORD_BITS'(extra_acks), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
